// File: rtl/fog_loop_pkg.sv
// fog_loop_pkg: shared FSM encoding and default widths/limits for the PI loop filter
package fog_loop_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    INTEG = 2'd2,
    OUT   = 2'd3
  } state_t;
  localparam int DATA_W_DEF  = 32;
  localparam int SAT_LIM_DEF = 134217727;
endpackage

// File: rtl/sat_clamp.sv
// sat_clamp: symmetric saturation of a (W+1)-bit signed sum down to W bits, with clip flag
module sat_clamp #(
  parameter int W   = 32,
  parameter int LIM = 134217727
) (
  input  logic signed [W:0]   x,
  output logic signed [W-1:0] y,
  output logic                clip
);
  localparam logic signed [W:0] hi = (W+1)'(LIM);
  localparam logic signed [W:0] lo = -hi;
  assign y    = x > hi ? hi[W-1:0] : x < lo ? lo[W-1:0] : x[W-1:0];
  assign clip = x > hi || x < lo;
endmodule

// File: rtl/loop_filter_pi.sv
// loop_filter_pi: 4-state PI loop filter (capture, shift, integrate, output); LOOP_FILTER_PI_DBG_EN adds debug mirror ports
module loop_filter_pi
  import fog_loop_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SAT_LIM = SAT_LIM_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [DATA_W-1:0] i_err,
  input  logic                     i_sync,
  input  logic                     i_loop_en,
  input  logic [4:0]               i_kp_shift,
  input  logic [4:0]               i_ki_shift,
  input  logic signed [DATA_W-1:0] i_open_step,
  output logic signed [DATA_W-1:0] o_step,
  output logic                     o_step_vld,
  output logic                     o_sat,
  output logic                     o_ovr
`ifdef LOOP_FILTER_PI_DBG_EN
  ,
  output logic signed [DATA_W-1:0] o_p_term,
  output logic signed [DATA_W-1:0] o_i_term,
  output logic signed [DATA_W-1:0] o_integ,
  output logic [1:0]               o_cstate
`endif
);
  state_t state, nxt;
  logic sync_q, sync_edge, int_clip, clip_i, clip_s, vld_nxt, sat_nxt;
  logic signed [DATA_W-1:0] err_q, p_q, i_q, integ, integ_c, step_c, step_nxt;
  logic signed [DATA_W:0] integ_sum, step_sum;
  assign sync_edge = i_sync & ~sync_q;
  assign integ_sum = {integ[DATA_W-1], integ} + {i_q[DATA_W-1], i_q};
  assign step_sum  = {integ[DATA_W-1], integ} + {p_q[DATA_W-1], p_q};
  sat_clamp #(.W(DATA_W), .LIM(SAT_LIM)) u_integ_clamp (
    .x(integ_sum), .y(integ_c), .clip(clip_i)
  );
  sat_clamp #(.W(DATA_W), .LIM(SAT_LIM)) u_step_clamp (
    .x(step_sum), .y(step_c), .clip(clip_s)
  );
  always_ff @(posedge i_clk)
    if (i_rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (sync_edge ? CALC : IDLE) :
          state == CALC  ? INTEG :
          state == INTEG ? OUT : IDLE;
  always_comb begin
    vld_nxt  = state == OUT;
    sat_nxt  = i_loop_en & (int_clip | clip_s);
    step_nxt = i_loop_en ? step_c : i_open_step;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      sync_q     <= 1'b0;
      err_q      <= '0;
      p_q        <= '0;
      i_q        <= '0;
      integ      <= '0;
      int_clip   <= 1'b0;
      o_step     <= '0;
      o_step_vld <= 1'b0;
      o_sat      <= 1'b0;
      o_ovr      <= 1'b0;
    end else begin
      sync_q     <= i_sync;
      o_step_vld <= vld_nxt;
      if (sync_edge && state != IDLE) o_ovr <= 1'b1;
      if (sync_edge && state == IDLE) err_q <= i_err;
      if (state == CALC) begin
        p_q <= err_q >>> i_kp_shift;
        i_q <= err_q >>> i_ki_shift;
      end
      if (state == INTEG) begin
        integ    <= i_loop_en ? integ_c : '0;
        int_clip <= i_loop_en & clip_i;
      end
      if (state == OUT) begin
        o_step <= step_nxt;
        o_sat  <= sat_nxt;
      end
    end
`ifdef LOOP_FILTER_PI_DBG_EN
  assign o_p_term = p_q;
  assign o_i_term = i_q;
  assign o_integ  = integ;
  assign o_cstate = state;
`endif
endmodule
